multi_seq: RTL and testbench



---
 rtl/multi_seq_pkg.sv | 12 +
 rtl/multi_seq.sv | 92 +++++++++
 tb/tb_multi_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/multi_seq_pkg.sv
// Shared widths and state encoding for the multi-beat instruction sequencer.
package multi_seq_pkg;

  localparam int unsigned MULTI_W = 5;
  localparam int unsigned OFF_W   = MULTI_W + 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/multi_seq.sv
// Multi-beat load/store sequencer: stalls the pipeline while stepping beat/register
// indices, pulses done after the last beat and holds interrupts off mid-operation.
module multi_seq
  import multi_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [MULTI_W-1:0] multi,
  input  logic [MULTI_W-1:0] ra_base,
  input  logic               mem_ready,
  input  logic               irq_in,
  output logic               stall,
  output logic [MULTI_W-1:0] beat,
  output logic [MULTI_W-1:0] reg_idx,
  output logic [OFF_W-1:0]   addr_off,
  output logic               active,
  output logic               done,
  output logic               irq_out
);

  state_t             r_state;
  logic [MULTI_W-1:0] r_cnt;
  logic [MULTI_W-1:0] r_total;
  logic [MULTI_W-1:0] r_base;
  logic               r_done;

  logic w_multi_op;
  logic w_accept;
  logic w_last;

  assign w_multi_op = instr_valid && (multi != '0);
  assign w_accept   = (r_state == ST_IDLE) && w_multi_op && mem_ready;
  assign w_last     = (r_state == ST_RUN) && mem_ready && (r_cnt == r_total);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_total <= '0;
      r_base  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_total <= multi;
            r_base  <= ra_base;
            r_cnt   <= MULTI_W'(1);
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Beat 0 was issued from IDLE, so cnt runs 1..total and never overflows.
          if (mem_ready) begin
            if (r_cnt == r_total) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + MULTI_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall and beat/register indices must react in the same cycle as decode.
  always_comb begin
    stall   = 1'b0;
    beat    = '0;
    reg_idx = ra_base;
    case (r_state)
      ST_IDLE: stall = w_multi_op;
      ST_RUN: begin
        beat    = r_cnt;
        reg_idx = r_base + r_cnt;
        stall   = !w_last;
      end
      default: stall = 1'b0;
    endcase
    if (reset) stall = 1'b0;
  end

  assign addr_off = {beat, 2'b00};
  assign active   = (r_state == ST_RUN);
  assign done     = r_done;
  assign irq_out  = irq_in && !reset && (r_state == ST_IDLE) && !stall;

endmodule

// File: tb/tb_multi_seq.sv
// Directed bench for multi_seq: per-cycle expected outputs computed by hand.
module tb_multi_seq;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic [4:0] multi;
  logic [4:0] ra_base;
  logic       mem_ready;
  logic       irq_in;
  logic       stall;
  logic [4:0] beat;
  logic [4:0] reg_idx;
  logic [6:0] addr_off;
  logic       active;
  logic       done;
  logic       irq_out;

  int    n_checks = 0;
  int    n_errors = 0;
  string g_test   = "init";

  multi_seq dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .multi       (multi),
    .ra_base     (ra_base),
    .mem_ready   (mem_ready),
    .irq_in      (irq_in),
    .stall       (stall),
    .beat        (beat),
    .reg_idx     (reg_idx),
    .addr_off    (addr_off),
    .active      (active),
    .done        (done),
    .irq_out     (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", g_test, tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check the outputs seen in that cycle, then advance.
  task automatic step(input logic rst, input logic iv, input logic [4:0] m,
                      input logic [4:0] rb, input logic mr, input logic irq,
                      input logic e_stall, input logic [4:0] e_beat, input logic [4:0] e_reg,
                      input logic e_active, input logic e_done, input logic e_irq);
    logic [6:0] e_off;
    reset = rst; instr_valid = iv; multi = m; ra_base = rb; mem_ready = mr; irq_in = irq;
    #1;
    e_off = {e_beat, 2'b00};
    chk("stall",    32'(stall),    32'(e_stall));
    chk("beat",     32'(beat),     32'(e_beat));
    chk("reg_idx",  32'(reg_idx),  32'(e_reg));
    chk("addr_off", 32'(addr_off), 32'(e_off));
    chk("active",   32'(active),   32'(e_active));
    chk("done",     32'(done),     32'(e_done));
    chk("irq_out",  32'(irq_out),  32'(e_irq));
    @(posedge clk);
    #1;
  endtask

  // Full op with memory always ready; multi/ra_base scrambled after accept, then
  // the trailing idle cycle carries the done pulse.
  task automatic run_op(input logic [4:0] m, input logic [4:0] rb);
    step(0, 1, m, rb, 1, 0, 1, 5'd0, rb, 0, 0, 0);
    for (int k = 1; k <= int'(m); k++)
      step(0, 0, ~m, ~rb, 1, 0, (k != int'(m)), 5'(k), 5'(int'(rb) + k), 1, 0, 0);
    step(0, 0, 5'd0, 5'd9, 1, 0, 0, 5'd0, 5'd9, 0, 1, 0);
  endtask

  initial begin
    reset = 1; instr_valid = 0; multi = 0; ra_base = 0; mem_ready = 0; irq_in = 0;

    g_test = "reset";
    @(posedge clk); #1;
    step(1, 1, 5'd3, 5'd4, 1, 1, 0, 5'd0, 5'd4, 0, 0, 0);
    step(0, 0, 5'd0, 5'd6, 1, 1, 0, 5'd0, 5'd6, 0, 0, 1);

    g_test = "m7_rb3";
    run_op(5'd7, 5'd3);

    g_test = "m4_wrap";
    run_op(5'd4, 5'd30);

    g_test = "m2_backpressure";
    step(0, 1, 5'd2, 5'd5, 1, 0, 1, 5'd0, 5'd5, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 5'd0, 5'd0, 0, 0, 1, 5'd1, 5'd6, 1, 0, 0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 1, 5'd1, 5'd6, 1, 0, 0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 5'd2, 5'd7, 1, 0, 0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 5'd0, 5'd0, 0, 1, 0);

    g_test = "idle_not_ready";
    step(0, 1, 5'd3, 5'd8, 0, 1, 1, 5'd0, 5'd8, 0, 0, 0);
    step(0, 1, 5'd3, 5'd8, 0, 1, 1, 5'd0, 5'd8, 0, 0, 0);
    step(0, 0, 5'd3, 5'd8, 1, 0, 0, 5'd0, 5'd8, 0, 0, 0);

    g_test = "irq_gate";
    step(0, 1, 5'd5, 5'd0, 1, 0, 1, 5'd0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 1, 5'd1, 5'd1, 1, 0, 0);
    for (int k = 2; k <= 5; k++)
      step(0, 0, 5'd0, 5'd0, 1, 1, (k != 5), 5'(k), 5'(k), 1, 0, 0);
    step(0, 0, 5'd0, 5'd0, 1, 1, 0, 5'd0, 5'd0, 0, 1, 1);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 5'd0, 5'd0, 0, 0, 0);

    g_test = "reset_mid_run";
    step(0, 1, 5'd7, 5'd1, 1, 0, 1, 5'd0, 5'd1, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 1, 5'd1, 5'd2, 1, 0, 0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 1, 5'd2, 5'd3, 1, 0, 0);
    step(1, 0, 5'd0, 5'd0, 1, 0, 0, 5'd3, 5'd4, 1, 0, 0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 5'd0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 5'd0, 5'd0, 0, 0, 0);

    g_test = "back_to_back";
    step(0, 1, 5'd1, 5'd2, 1, 0, 1, 5'd0, 5'd2, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 5'd1, 5'd3, 1, 0, 0);
    step(0, 1, 5'd1, 5'd10, 1, 0, 1, 5'd0, 5'd10, 0, 1, 0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 5'd1, 5'd11, 1, 0, 0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 5'd0, 5'd0, 0, 1, 0);

    g_test = "multi0_stream";
    for (int i = 0; i < 4; i++)
      step(0, 1, 5'd0, 5'(i + 12), 1, 1, 0, 5'd0, 5'(i + 12), 0, 0, 1);

    g_test = "m31_full";
    run_op(5'd31, 5'd0);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 5'd0, 5'd0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
